// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit accumulator CPU control path.
//   - opcode constants, ALU function codes
//   - instruction field positions (op, operand address)
//   - sequencer state enum and decoded op class enum
package cpu_pkg;

   // instruction fields: op = IR[7:5], a = IR[4:0]
   localparam int OP_W   = 3;
   localparam int OP_LSB = 5;
   localparam int A_LSB  = 0;

   localparam logic [OP_W-1:0] OP_ADD   = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB   = 3'b001;
   localparam logic [OP_W-1:0] OP_LOAD  = 3'b010;
   localparam logic [OP_W-1:0] OP_STORE = 3'b011;
   localparam logic [OP_W-1:0] OP_JMP   = 3'b100;
   localparam logic [OP_W-1:0] OP_JZ    = 3'b101;
   localparam logic [OP_W-1:0] OP_CLR   = 3'b110;
   localparam logic [OP_W-1:0] OP_HALT  = 3'b111;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_PASS = 2'b10;
   localparam logic [1:0] ALU_ZERO = 2'b11;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_OPERAND, S_EXECUTE, S_STORE, S_HALT
   } state_t;

   // what DECODE does next for a given opcode
   typedef enum logic [2:0] {
      C_OPERAND, C_STORE, C_EXEC, C_JMP, C_JZ, C_HALT
   } op_class_t;

endpackage

// File: rtl/cpu_decode.sv
// cpu_decode: combinational opcode decoder.
//   op_i          opcode field of IR
//   alu_func_o    ALU function for this instruction
//   alu_in1_sel_o 1 = ALU in1 from MDR (LOAD), 0 = accumulator
//   op_class_o    sequencing class used by the FSM in DECODE
module cpu_decode
   import cpu_pkg::*;
(
   input  logic [OP_W-1:0] op_i,
   output logic [1:0]      alu_func_o,
   output logic            alu_in1_sel_o,
   output op_class_t       op_class_o
);

   always_comb begin
      alu_func_o    = ALU_ZERO;
      alu_in1_sel_o = 1'b0;
      op_class_o    = C_HALT;
      unique case (op_i)
         OP_ADD:   begin alu_func_o = ALU_ADD;  op_class_o = C_OPERAND; end
         OP_SUB:   begin alu_func_o = ALU_SUB;  op_class_o = C_OPERAND; end
         OP_LOAD:  begin
            alu_func_o    = ALU_PASS;
            alu_in1_sel_o = 1'b1;
            op_class_o    = C_OPERAND;
         end
         OP_STORE: op_class_o = C_STORE;
         OP_JMP:   op_class_o = C_JMP;
         OP_JZ:    op_class_o = C_JZ;
         OP_CLR:   begin alu_func_o = ALU_ZERO; op_class_o = C_EXEC; end
         default:  op_class_o = C_HALT;
      endcase
   end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle sequencer for the 8-bit accumulator CPU.
// Owns PC and IR, fetches over a req/ack memory port, drives ALU function
// and datapath strobes.
//   clk, reset             clock, synchronous active-high reset
//   mem_req/we/addr        memory request (held until ack edge)
//   mem_rdata, mem_ack     read data / transfer complete
//   acc_zero               datapath accumulator == 0
//   alu_func, alu_in1_sel  ALU controls, stable from DECODE to next DECODE
//   acc_load, mdr_load     one-cycle datapath strobes
//   pc, halted             program counter, HALT indication
module cpu_seq_ctrl
   import cpu_pkg::*;
#(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 8,
   parameter int RESET_PC = 0
)(
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   input  logic              acc_zero,
   output logic [1:0]        alu_func,
   output logic              alu_in1_sel,
   output logic              acc_load,
   output logic              mdr_load,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   state_t              state_q;
   logic [ADDR_W-1:0]   pc_q, addr_q;
   logic [DATA_W-1:0]   ir_q;
   logic                req_q, we_q, sel_q, acc_load_q, halted_q;
   logic [1:0]          func_q;

   logic [1:0]          dec_func;
   logic                dec_sel;
   op_class_t           dec_cls;
   logic [ADDR_W-1:0]   a_w;

   assign a_w = ir_q[A_LSB +: ADDR_W];

   cpu_decode u_dec (
      .op_i          (ir_q[OP_LSB +: OP_W]),
      .alu_func_o    (dec_func),
      .alu_in1_sel_o (dec_sel),
      .op_class_o    (dec_cls)
   );

   // Requests are issued on the edge entering a requesting state so the
   // first request cycle coincides with the state. The exceptions are the
   // first FETCH after reset and the FETCH following a STORE ack: there
   // mem_req must drop for a cycle, so FETCH raises it itself.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_FETCH;
         pc_q       <= ADDR_W'(RESET_PC);
         ir_q       <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         func_q     <= ALU_ZERO;
         sel_q      <= 1'b0;
         acc_load_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         acc_load_q <= 1'b0;
         unique case (state_q)
            S_FETCH: begin
               if (!req_q) begin
                  req_q  <= 1'b1;
                  we_q   <= 1'b0;
                  addr_q <= pc_q;
               end else if (mem_ack) begin
                  ir_q    <= mem_rdata;
                  pc_q    <= pc_q + ADDR_W'(1);
                  req_q   <= 1'b0;
                  state_q <= S_DECODE;
               end
            end
            S_DECODE: begin
               func_q <= dec_func;
               sel_q  <= dec_sel;
               unique case (dec_cls)
                  C_OPERAND: begin
                     req_q <= 1'b1; we_q <= 1'b0; addr_q <= a_w;
                     state_q <= S_OPERAND;
                  end
                  C_STORE: begin
                     req_q <= 1'b1; we_q <= 1'b1; addr_q <= a_w;
                     state_q <= S_STORE;
                  end
                  C_EXEC: begin
                     acc_load_q <= 1'b1;
                     state_q    <= S_EXECUTE;
                  end
                  C_JMP: begin
                     pc_q <= a_w;
                     req_q <= 1'b1; we_q <= 1'b0; addr_q <= a_w;
                     state_q <= S_FETCH;
                  end
                  C_JZ: begin
                     if (acc_zero) begin
                        pc_q   <= a_w;
                        addr_q <= a_w;
                     end else begin
                        addr_q <= pc_q;
                     end
                     req_q <= 1'b1; we_q <= 1'b0;
                     state_q <= S_FETCH;
                  end
                  default: begin
                     halted_q <= 1'b1;
                     state_q  <= S_HALT;
                  end
               endcase
            end
            S_OPERAND: begin
               if (mem_ack) begin
                  req_q      <= 1'b0;
                  acc_load_q <= 1'b1;
                  state_q    <= S_EXECUTE;
               end
            end
            S_EXECUTE: begin
               req_q <= 1'b1; we_q <= 1'b0; addr_q <= pc_q;
               state_q <= S_FETCH;
            end
            S_STORE: begin
               if (mem_ack) begin
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  state_q <= S_FETCH;
               end
            end
            S_HALT: ;
            default: state_q <= S_FETCH;
         endcase
      end
   end

   assign mem_req     = req_q;
   assign mem_we      = we_q;
   assign mem_addr    = addr_q;
   assign alu_func    = func_q;
   assign alu_in1_sel = sel_q;
   assign acc_load    = acc_load_q;
   assign pc          = pc_q;
   assign halted      = halted_q;
   // MDR captures in the ack cycle itself, so this strobe is decoded
   assign mdr_load    = !reset && (state_q == S_OPERAND) && req_q && mem_ack;

endmodule
